uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that lets up to NUM_REQ byte-stream requesters share one UART transmit FIFO. It runs on the same baud-sample tick (s_tick) as the UART FIFOs and drives the TX FIFO write port (wr, w_data, full). A granted requester holds the FIFO for a whole frame, ended by req_last. The grant is cut short when MAX_BURST bytes have been sent or the holder has stalled for IDLE_TIMEOUT ticks.

## Interface
- DATA_SIZE, 8, byte width
- NUM_REQ, 4, number of requesters (≥2)
- MAX_BURST, 16, max bytes per grant before forced rotation (≥1)
- IDLE_TIMEOUT, 64, s_ticks a holder may present no valid before release; 0 = disabled
- REQ_W, $clog2(NUM_REQ), grant index width
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- s_tick  in  1  sample-tick enable; all state advances only on clk edges with s_tick=1
- req_valid  in  NUM_REQ  per-requester byte valid
- req_last  in  NUM_REQ  byte is last of frame
- req_data  in  NUM_REQ*DATA_SIZE  flattened; requester i at [i*DATA_SIZE +: DATA_SIZE]
- req_ready  out  NUM_REQ  byte accepted if valid&ready on an s_tick edge
- fifo_full  in  1  TX FIFO full
- fifo_wr  out  1  TX FIFO write request (FIFO qualifies with s_tick)
- fifo_w_data  out  DATA_SIZE  TX FIFO write data
- grant_id  out  REQ_W  current/last granted requester
- busy  out  1  a grant is active
- frame_done  out  1  one-clk pulse: frame completed with req_last
- timeout  out  1  one-clk pulse: grant revoked by IDLE_TIMEOUT

## Operation
- States: IDLE, GRANT. Registers: state, grant_id, rr_ptr (REQ_W), burst_cnt ($clog2(MAX_BURST+1)), idle_cnt.
- IDLE, s_tick, any req_valid: grant_id <= first i with req_valid[i], searched rr_ptr, rr_ptr+1, … wrapping mod NUM_REQ. Also burst_cnt <= 0, idle_cnt <= 0, state <= GRANT. With no valid, stay in IDLE.
- GRANT, combinational outputs, g = grant_id:
  - req_ready[g] = ~fifo_full; all other ready bits 0.
  - fifo_wr = req_valid[g] & ~fifo_full.
  - fifo_w_data = req_data slice g.
  - busy = 1.
- IDLE: req_ready=0, fifo_wr=0, fifo_w_data=0, busy=0.
- Transfer = s_tick & fifo_wr. On a transfer:
  - burst_cnt += 1; idle_cnt <= 0.
  - If req_last[g]: state <= IDLE, rr_ptr <= (g+1) mod NUM_REQ, frame_done pulses.
  - Else if burst_cnt == MAX_BURST-1: same release, but no frame_done (preemption). The requester re-arbitrates later and continues its frame.
- GRANT, s_tick, ~req_valid[g]:
  - idle_cnt += 1.
  - If IDLE_TIMEOUT≠0 and idle_cnt == IDLE_TIMEOUT-1: release as above, timeout pulses.
- GRANT, s_tick, req_valid[g] & fifo_full: stall. No counter changes, no timeout.
- A grant ends on req_last / burst / timeout.
- rr_ptr wraps NUM_REQ-1 → 0; NUM_REQ non-power-of-2 uses explicit compare, not bit truncation.

## Timing
- Reset: state=IDLE, grant_id=0, rr_ptr=0, counters=0. All outputs 0 (req_ready, fifo_wr, fifo_w_data, busy, frame_done, timeout).
- Grant latency: 1 s_tick edge from IDLE with a valid request. First byte can be written on the next s_tick edge.
- Bubble: exactly one s_tick period in IDLE between consecutive grants.
- Throughput inside a grant: one byte per s_tick while ~fifo_full.
- req_ready, fifo_wr and fifo_w_data are combinational from registered state and inputs; no register stage.
- frame_done and timeout are registered, high for one clk cycle after the releasing edge.
- Reset mid-frame: immediate asynchronous return to reset values. Bytes already written stay in the FIFO (the FIFO has its own reset).
- Requester changing data while valid&~ready: allowed; whatever is sampled on the transfer edge is written.

## Structure
- Shared package uart_pkg: state encodings ARB_IDLE/ARB_GRANT and default DATA_SIZE.
- Sub-module uart_rr_picker: combinational rotating-priority picker (req vector, rr_ptr → found, index), parameterised by NUM_REQ.
- Top instantiates the picker, the FSM and the counters. It integrates by driving uart_fifo w_data/wr/full in place of a direct write.

## Test plan
- Single frame: req0 sends 0xA1, 0xA2, 0xA3 (last on 0xA3), FIFO never full → three fifo_wr ticks with that data, grant_id=0, one frame_done, busy drops after the third tick.
- Rotation: req0 and req2 valid from reset, each with a 2-byte frame, then req0 requests again → FIFO order is req0 frame, req2 frame, req0 frame; rr_ptr reads 1, 3, 1.
- Burst cut: MAX_BURST=4, req1 sends a 6-byte frame while req3 waits with 1 byte → 4 req1 bytes, no frame_done, req3 byte, then the 2 remaining req1 bytes and frame_done.
- Backpressure: fifo_full high for 5 s_ticks mid-frame → req_ready=0, fifo_wr=0, burst_cnt and idle_cnt frozen, no timeout; the frame resumes byte-exact.
- Timeout: IDLE_TIMEOUT=8, holder drops valid after 1 byte → release on the 8th idle s_tick, timeout pulses once, waiting req granted next.
- Reset mid-frame: reset_n low between s_ticks → all outputs 0 immediately, rr_ptr=0; after release, arbitration restarts from req0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART package: arbiter state encodings, default byte width and the
// wrapping index helper used by the round-robin logic.
package uart_pkg;

    localparam int UART_DATA_SIZE = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // (base + step) mod n for base < n and step <= n; explicit compare so a
    // non-power-of-2 requester count wraps correctly.
    function automatic int rr_wrap_add(input int base, input int step, input int n);
        int sum;
        sum = base + step;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Rotating-priority picker: returns the first asserted request at or after
// rr_ptr, wrapping past the last requester back to requester 0.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_W-1:0]   rr_ptr,
    output logic               found,
    output logic [REQ_W-1:0]   index
);

    logic [REQ_W-1:0] cand;

    // Scan candidates in rotated order; the first hit wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = REQ_W'(rr_wrap_add(int'(rr_ptr), k, NUM_REQ));
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among several
// byte-stream requesters. A grant lasts one frame, cut short by a burst
// limit or by the holder going quiet for too many sample ticks.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_SIZE    = UART_DATA_SIZE,
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64,
    parameter int REQ_W        = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_tick,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wr,
    output logic [DATA_SIZE-1:0]         fifo_w_data,
    output logic [REQ_W-1:0]             grant_id,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         timeout
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    // Counter values seen on the tick that triggers a forced release.
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);

    arb_state_t         state;
    logic [REQ_W-1:0]   rr_ptr;
    logic [BURST_W-1:0] burst_cnt;
    logic [IDLE_W-1:0]  idle_cnt;

    logic               pick_found;
    logic [REQ_W-1:0]   pick_index;
    logic               holder_valid;
    logic [REQ_W-1:0]   next_ptr;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_index)
    );

    assign holder_valid = req_valid[grant_id];
    // After any release, priority starts just past the departing holder.
    assign next_ptr     = REQ_W'(rr_wrap_add(int'(grant_id), 1, NUM_REQ));

    // Steer the granted requester onto the FIFO write port; quiet when idle.
    always_comb begin
        req_ready   = '0;
        fifo_wr     = 1'b0;
        fifo_w_data = '0;
        busy        = 1'b0;
        if (state == ARB_GRANT) begin
            req_ready[grant_id] = ~fifo_full;
            fifo_wr             = holder_valid & ~fifo_full;
            fifo_w_data         = req_data[int'(grant_id)*DATA_SIZE +: DATA_SIZE];
            busy                = 1'b1;
        end
    end

    // Grant FSM with burst/idle counters; release pulses last one clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            idle_cnt   <= '0;
            frame_done <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            timeout    <= 1'b0;
            if (s_tick) begin
                case (state)
                    ARB_IDLE: begin
                        if (pick_found) begin
                            grant_id  <= pick_index;
                            burst_cnt <= '0;
                            idle_cnt  <= '0;
                            state     <= ARB_GRANT;
                        end
                    end
                    ARB_GRANT: begin
                        if (fifo_wr) begin
                            burst_cnt <= burst_cnt + 1'b1;
                            idle_cnt  <= '0;
                            if (req_last[grant_id]) begin
                                state      <= ARB_IDLE;
                                rr_ptr     <= next_ptr;
                                frame_done <= 1'b1;
                            end else if (burst_cnt == BURST_LAST) begin
                                // Preempted mid-frame; the holder re-arbitrates.
                                state  <= ARB_IDLE;
                                rr_ptr <= next_ptr;
                            end
                        end else if (!holder_valid) begin
                            idle_cnt <= idle_cnt + 1'b1;
                            if ((IDLE_TIMEOUT != 0) && (idle_cnt == IDLE_LAST)) begin
                                state   <= ARB_IDLE;
                                rr_ptr  <= next_ptr;
                                timeout <= 1'b1;
                            end
                        end
                        // Valid but FIFO full: stall, counters hold.
                    end
                    default: state <= ARB_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the DUT,
// a monitor logs every FIFO write, and logs are compared to hand-built lists.
module tb_uart_tx_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int RW = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              s_tick = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              fifo_full = 1'b0;
    logic              fifo_wr;
    logic [DW-1:0]     fifo_w_data;
    logic [RW-1:0]     grant_id;
    logic              busy;
    logic              frame_done;
    logic              timeout;

    int checks = 0;
    int failures = 0;

    logic [8:0]  rq [NR][$];
    logic [NR-1:0] hold = '0;
    logic [9:0]  wlog [$];
    logic [9:0]  exp_log [$];
    int          rrlog [$];
    int          fd_cnt = 0;
    int          to_cnt = 0;

    uart_tx_arbiter #(
        .DATA_SIZE    (DW),
        .NUM_REQ      (NR),
        .MAX_BURST    (4),
        .IDLE_TIMEOUT (8),
        .REQ_W        (RW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_tick      (s_tick),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Log accepted FIFO writes and release pulses as seen at each edge.
    always @(posedge clk) begin
        if (reset_n && s_tick && fifo_wr) wlog.push_back({grant_id, fifo_w_data});
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (timeout) to_cnt <= to_cnt + 1;
        if (frame_done || timeout) rrlog.push_back(int'(dut.rr_ptr));
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() != 0 && !hold[i]) begin
                req_valid[i] = 1'b1;
                req_last[i]  = rq[i][0][8];
                req_data[i*DW +: DW] = rq[i][0][7:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    // One clock with s_tick = tk; requesters pop bytes the DUT accepted.
    task automatic step(input bit tk);
        logic [NR-1:0] acc;
        s_tick = tk;
        drive();
        #2;
        acc = {NR{tk}} & req_valid & req_ready & {NR{reset_n}};
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i]) void'(rq[i].pop_front());
        s_tick = 1'b0;
        drive();
        #1;
    endtask

    task automatic push_frame(input int r, input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) rq[r].push_back({(k == n - 1), first + 8'(k)});
        drive();
        #1;
    endtask

    task automatic run_until_idle(input string tag);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            step(1'b1);
            step(1'b0);
            n++;
            done = !busy && hold == '0 && (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()) == 0;
        end
        check_eq({tag, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic check_log(input string tag, input int base);
        check_eq({tag, "_count"}, 32'(wlog.size() - base), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++) begin
            if (base + i < wlog.size()) check_eq($sformatf("%s_w%0d", tag, i), 32'(wlog[base + i]), 32'(exp_log[i]));
            else check_eq($sformatf("%s_w%0d", tag, i), 32'hdead, 32'(exp_log[i]));
        end
    endtask

    initial begin
        int wb, fb, tb0, rb;

        // Reset state
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ready", 32'(req_ready), 0);
        check_eq("rst_wr", 32'(fifo_wr), 0);
        check_eq("rst_data", 32'(fifo_w_data), 0);
        check_eq("rst_gid", 32'(grant_id), 0);
        check_eq("rst_pulses", 32'({frame_done, timeout}), 0);
        step(1'b0);
        step(1'b0);
        reset_n = 1'b1;

        // Single frame from req0
        wb = wlog.size(); fb = fd_cnt;
        push_frame(0, 8'hA1, 3);
        check_eq("sf_idle_busy", 32'(busy), 0);
        check_eq("sf_idle_wr", 32'(fifo_wr), 0);
        step(1'b1);
        check_eq("sf_busy", 32'(busy), 1);
        check_eq("sf_gid", 32'(grant_id), 0);
        check_eq("sf_ready", 32'(req_ready), 32'h1);
        check_eq("sf_wr", 32'(fifo_wr), 1);
        check_eq("sf_data0", 32'(fifo_w_data), 32'hA1);
        step(1'b0);
        check_eq("sf_gated", 32'(fifo_w_data), 32'hA1);
        step(1'b1);
        check_eq("sf_data1", 32'(fifo_w_data), 32'hA2);
        step(1'b1);
        check_eq("sf_busy_last", 32'(busy), 1);
        step(1'b1);
        check_eq("sf_busy_end", 32'(busy), 0);
        check_eq("sf_frame_done", 32'(frame_done), 1);
        check_eq("sf_rr", 32'(dut.rr_ptr), 1);
        step(1'b0);
        check_eq("sf_fd_pulse", 32'(frame_done), 0);
        exp_log = '{10'h0A1, 10'h0A2, 10'h0A3};
        check_log("sf", wb);
        check_eq("sf_fd_cnt", 32'(fd_cnt - fb), 1);

        // Rotation from reset: req0, req2, req0
        reset_n = 1'b0;
        step(1'b0);
        reset_n = 1'b1;
        wb = wlog.size(); fb = fd_cnt; rb = rrlog.size();
        push_frame(0, 8'h10, 2);
        push_frame(2, 8'h20, 2);
        push_frame(0, 8'h30, 2);
        run_until_idle("rot");
        exp_log = '{10'h010, 10'h011, 10'h220, 10'h221, 10'h030, 10'h031};
        check_log("rot", wb);
        check_eq("rot_fd_cnt", 32'(fd_cnt - fb), 3);
        check_eq("rot_rr_n", 32'(rrlog.size() - rb), 3);
        check_eq("rot_rr0", 32'(rrlog[rb]), 1);
        check_eq("rot_rr1", 32'(rrlog[rb + 1]), 3);
        check_eq("rot_rr2", 32'(rrlog[rb + 2]), 1);

        // Burst cut: 6-byte req1 frame preempted after 4 bytes by waiting req3
        wb = wlog.size(); fb = fd_cnt; rb = rrlog.size();
        push_frame(1, 8'h40, 6);
        push_frame(3, 8'h50, 1);
        run_until_idle("bc");
        exp_log = '{10'h140, 10'h141, 10'h142, 10'h143, 10'h350, 10'h144, 10'h145};
        check_log("bc", wb);
        check_eq("bc_fd_cnt", 32'(fd_cnt - fb), 2);
        check_eq("bc_rr_n", 32'(rrlog.size() - rb), 2);
        check_eq("bc_rr0", 32'(rrlog[rb]), 0);
        check_eq("bc_rr1", 32'(rrlog[rb + 1]), 2);

        // Backpressure: FIFO full for 5 ticks after the first byte
        wb = wlog.size(); fb = fd_cnt; tb0 = to_cnt;
        push_frame(2, 8'h60, 3);
        step(1'b1);
        step(1'b1);
        fifo_full = 1'b1;
        #1;
        check_eq("bp_ready", 32'(req_ready), 0);
        check_eq("bp_wr", 32'(fifo_wr), 0);
        for (int i = 0; i < 5; i++) step(1'b1);
        check_eq("bp_busy", 32'(busy), 1);
        check_eq("bp_burst", 32'(dut.burst_cnt), 1);
        check_eq("bp_idle", 32'(dut.idle_cnt), 0);
        fifo_full = 1'b0;
        run_until_idle("bp");
        exp_log = '{10'h260, 10'h261, 10'h262};
        check_log("bp", wb);
        check_eq("bp_fd_cnt", 32'(fd_cnt - fb), 1);
        check_eq("bp_to_cnt", 32'(to_cnt - tb0), 0);
        check_eq("bp_rr", 32'(dut.rr_ptr), 3);

        // Timeout: req3 goes quiet after one byte while req1 waits
        wb = wlog.size(); fb = fd_cnt; tb0 = to_cnt;
        push_frame(3, 8'h70, 2);
        push_frame(1, 8'h80, 1);
        step(1'b1);
        check_eq("to_gid", 32'(grant_id), 3);
        step(1'b1);
        hold[3] = 1'b1;
        drive();
        #1;
        for (int i = 0; i < 7; i++) step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check_eq("to_busy7", 32'(busy), 1);
        check_eq("to_none7", 32'(to_cnt - tb0), 0);
        step(1'b1);
        check_eq("to_busy8", 32'(busy), 0);
        check_eq("to_pulse", 32'(timeout), 1);
        check_eq("to_fd", 32'(frame_done), 0);
        check_eq("to_rr", 32'(dut.rr_ptr), 0);
        step(1'b1);
        check_eq("to_next_gid", 32'(grant_id), 1);
        hold[3] = 1'b0;
        run_until_idle("to");
        exp_log = '{10'h370, 10'h180, 10'h371};
        check_log("to", wb);
        check_eq("to_cnt", 32'(to_cnt - tb0), 1);
        check_eq("to_fd_cnt", 32'(fd_cnt - fb), 2);

        // Reset mid-frame; arbitration restarts from req0
        push_frame(1, 8'hC0, 1);
        run_until_idle("rm_pre");
        wb = wlog.size();
        push_frame(2, 8'h90, 3);
        step(1'b1);
        step(1'b1);
        check_eq("rm_rr_before", 32'(dut.rr_ptr), 2);
        check_eq("rm_wr_before", 32'(fifo_wr), 1);
        check_eq("rm_data_before", 32'(fifo_w_data), 32'h91);
        reset_n = 1'b0;
        #1;
        check_eq("rm_busy", 32'(busy), 0);
        check_eq("rm_ready", 32'(req_ready), 0);
        check_eq("rm_wr", 32'(fifo_wr), 0);
        check_eq("rm_data", 32'(fifo_w_data), 0);
        check_eq("rm_gid", 32'(grant_id), 0);
        check_eq("rm_rr", 32'(dut.rr_ptr), 0);
        step(1'b0);
        reset_n = 1'b1;
        push_frame(0, 8'hB0, 1);
        run_until_idle("rm");
        exp_log = '{10'h290, 10'h0B0, 10'h291, 10'h292};
        check_log("rm", wb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
